// File: rtl/led_rgb_pattern_seq_if.sv
// Signal bundle between the register block (master) and the LED pattern sequencer (slave).
interface led_rgb_pattern_seq_if #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [31:0]   tbl_wdata;
    logic [AW-1:0] seq_last;
    logic          loop_en;
    logic [15:0]   prescale;
    logic [31:0]   duration;
    logic          start;
    logic          stop;

    logic          busy;
    logic          done;
    logic [AW-1:0] step_idx;
    logic          mode_r, mode_g, mode_b;
    logic          enable_r, enable_g, enable_b;
    logic          holded_r, holded_g, holded_b;
    logic [31:0]   duration_r, duration_g, duration_b;

    modport master (
        output tbl_we, tbl_addr, tbl_wdata, seq_last, loop_en, prescale, duration, start, stop,
        input  busy, done, step_idx,
        input  mode_r, mode_g, mode_b, enable_r, enable_g, enable_b,
        input  holded_r, holded_g, holded_b, duration_r, duration_g, duration_b
    );

    modport slave (
        input  tbl_we, tbl_addr, tbl_wdata, seq_last, loop_en, prescale, duration, start, stop,
        output busy, done, step_idx,
        output mode_r, mode_g, mode_b, enable_r, enable_g, enable_b,
        output holded_r, holded_g, holded_b, duration_r, duration_g, duration_b
    );
endinterface

// File: rtl/led_rgb_pattern_seq.sv
// RGB LED pattern sequencer: plays a programmable table of LED states with per-step dwell.
// Define LED_SEQ_PRESCALE_EN to build the tick prescaler; otherwise every clock is a tick.
//
// state  | meaning
// IDLE   | enables off, waiting for start
// RUN    | playing table entry step_idx, dwell counter running
// DONE   | one-cycle done pulse after a non-looping sequence
module led_rgb_pattern_seq #(
    parameter int DEPTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    led_rgb_pattern_seq_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [31:0]   tbl_q [DEPTH];
    logic [AW-1:0] step_q;
    logic [2:0]    en_q, mode_q, hold_q;
    logic [22:0]   dwell_q;
    logic [31:0]   dur_q;

    logic [AW-1:0] nxt_idx;
    logic [31:0]   nxt_entry;
    logic          tick;

    always_ff @(posedge aclk) begin
        if (bus.tbl_we) begin
            tbl_q[bus.tbl_addr] <= bus.tbl_wdata;
        end
    end

`ifdef LED_SEQ_PRESCALE_EN
    logic [15:0] psc_q;

    assign tick = (psc_q == bus.prescale);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            psc_q <= '0;
        end else if (state_q == S_RUN && !bus.stop && !tick) begin
            psc_q <= psc_q + 16'd1;
        end else begin
            psc_q <= '0;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Entry to load on a start (IDLE) or on a step end (RUN); wraps to 0 past seq_last.
    always_comb begin
        nxt_idx = '0;
        if (state_q == S_RUN && step_q < bus.seq_last) begin
            nxt_idx = step_q + AW'(1);
        end
        nxt_entry = tbl_q[nxt_idx];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            en_q    <= '0;
            mode_q  <= '0;
            hold_q  <= '0;
            dwell_q <= '0;
            dur_q   <= '0;
        end else begin
            dur_q <= bus.duration;
            if (bus.stop) begin
                state_q <= S_IDLE;
                en_q    <= '0;
                step_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        en_q <= '0;
                        if (bus.start) begin
                            state_q <= S_RUN;
                            step_q  <= '0;
                            en_q    <= nxt_entry[2:0];
                            mode_q  <= nxt_entry[5:3];
                            hold_q  <= nxt_entry[8:6];
                            dwell_q <= nxt_entry[31:9];
                        end
                    end
                    S_RUN: begin
                        // Dwell of zero holds the step until stop.
                        if (tick && dwell_q != '0) begin
                            if (dwell_q == 23'd1) begin
                                if (step_q < bus.seq_last || bus.loop_en) begin
                                    step_q  <= nxt_idx;
                                    en_q    <= nxt_entry[2:0];
                                    mode_q  <= nxt_entry[5:3];
                                    hold_q  <= nxt_entry[8:6];
                                    dwell_q <= nxt_entry[31:9];
                                end else begin
                                    state_q <= S_DONE;
                                    en_q    <= '0;
                                end
                            end else begin
                                dwell_q <= dwell_q - 23'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        en_q    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.step_idx   = step_q;
    assign bus.enable_r   = en_q[0];
    assign bus.enable_g   = en_q[1];
    assign bus.enable_b   = en_q[2];
    assign bus.mode_r     = mode_q[0];
    assign bus.mode_g     = mode_q[1];
    assign bus.mode_b     = mode_q[2];
    assign bus.holded_r   = hold_q[0];
    assign bus.holded_g   = hold_q[1];
    assign bus.holded_b   = hold_q[2];
    assign bus.duration_r = dur_q;
    assign bus.duration_g = dur_q;
    assign bus.duration_b = dur_q;

endmodule

// File: tb/tb_led_rgb_pattern_seq.sv
// Self-checking bench for led_rgb_pattern_seq: vector table plus directed multi-cycle sequences.
module tb_led_rgb_pattern_seq;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef LED_SEQ_PRESCALE_EN
    localparam int PSC_EN = 1;
`else
    localparam int PSC_EN = 0;
`endif

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    led_rgb_pattern_seq_if #(.DEPTH(DEPTH)) bus();

    led_rgb_pattern_seq #(.DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    wire [2:0] en_w   = {bus.enable_b, bus.enable_g, bus.enable_r};
    wire [2:0] mode_w = {bus.mode_b, bus.mode_g, bus.mode_r};
    wire [2:0] hold_w = {bus.holded_b, bus.holded_g, bus.holded_r};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          start;
        logic          stop;
        logic [2:0]    en;
        logic          busy;
        logic          done;
        logic          chk_step;
        logic [AW-1:0] step;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [31:0] ent(input logic [2:0] en, input logic [2:0] mode,
                                        input logic [2:0] hold, input int dwell);
        return {dwell[22:0], hold, mode, en};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data);
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = addr;
        bus.tbl_wdata = data;
        cyc();
        bus.tbl_we    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic run_len(input logic [2:0] e, output int n);
        n = 0;
        while (en_w == e && n < 200) begin
            n++;
            cyc();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;
        int pf;
        pf = PSC_EN ? 5 : 1;

        vecs[0]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd0};
        vecs[2]  = '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd0};
        vecs[3]  = '{1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[4]  = '{1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 3'd1};
        vecs[5]  = '{1'b0, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 3'd2};
        vecs[6]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[7]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd0};
        vecs[9]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd0};
        vecs[10] = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 3'd0};
        vecs[11] = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 3'd0};
        vecs[12] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'd0};

        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = '0;
        bus.tbl_wdata = '0;
        bus.seq_last  = 3'd2;
        bus.loop_en   = 1'b0;
        bus.prescale  = 16'd0;
        bus.duration  = 32'h1234_5678;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;

        #12;
        chk("reset_outputs", {bus.busy, bus.done, bus.step_idx, en_w, mode_w, hold_w}, 64'd0);
        chk("reset_duration", {bus.duration_r, bus.duration_g}, 64'd0);
        aresetn = 1'b1;
        cyc();
        chk("duration_reg", {bus.duration_g, bus.duration_b}, 64'h1234_5678_1234_5678);

        wr(3'd0, ent(3'b001, 3'b101, 3'b010, 3));
        wr(3'd1, ent(3'b010, 3'b000, 3'b000, 2));
        wr(3'd2, ent(3'b100, 3'b000, 3'b000, 1));

        // basic sequence, done pulse, start in DONE/RUN, stop, start+stop
        for (int i = 0; i < 13; i++) begin
            bus.start = vecs[i].start;
            bus.stop  = vecs[i].stop;
            cyc();
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            n_tests++;
            if (en_w !== vecs[i].en || bus.busy !== vecs[i].busy || bus.done !== vecs[i].done ||
                (vecs[i].chk_step && bus.step_idx !== vecs[i].step)) begin
                n_fail++;
                $display("FAIL vec%0d: got en=%b busy=%b done=%b step=%0d expected en=%b busy=%b done=%b step=%0d",
                         i, en_w, bus.busy, bus.done, bus.step_idx,
                         vecs[i].en, vecs[i].busy, vecs[i].done, vecs[i].step);
            end
        end

        // prescaled step lengths
        bus.prescale = 16'd4;
        pulse_start();
        chk("A_mode", mode_w, 3'b101);
        chk("A_hold", hold_w, 3'b010);
        run_len(3'b001, n); chk("A_len0", n, 3 * pf);
        run_len(3'b010, n); chk("A_len1", n, 2 * pf);
        run_len(3'b100, n); chk("A_len2", n, 1 * pf);
        chk("A_done", {bus.done, bus.busy, en_w}, {1'b1, 1'b0, 3'b000});
        cyc();
        chk("A_idle", {bus.done, bus.busy}, 2'b00);

        // looping, then loop_en cleared during step 1
        bus.prescale = 16'd0;
        bus.seq_last = 3'd1;
        bus.loop_en  = 1'b1;
        pulse_start();
        run_len(3'b001, n); chk("B_len0a", n, 3);
        run_len(3'b010, n); chk("B_len1a", n, 2);
        run_len(3'b001, n); chk("B_len0b", n, 3);
        chk("B_step1", bus.step_idx, 3'd1);
        bus.loop_en = 1'b0;
        run_len(3'b010, n); chk("B_len1b", n, 2);
        chk("B_done", {bus.done, bus.busy, en_w}, {1'b1, 1'b0, 3'b000});

        // dwell 0 holds until stop; stop gives no done
        cyc();
        wr(3'd0, ent(3'b011, 3'b000, 3'b000, 0));
        pulse_start();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (en_w !== 3'b011 || bus.busy !== 1'b1) bad++;
            cyc();
        end
        chk("C_hold", bad, 0);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        chk("C_stop", {en_w, bus.busy, bus.done, bus.step_idx}, 64'd0);
        cyc();
        chk("C_nodone", {bus.done, bus.busy}, 2'b00);

        // asynchronous reset during step 1, then replay with fresh entries
        wr(3'd0, ent(3'b001, 3'b110, 3'b101, 3));
        bus.seq_last = 3'd2;
        pulse_start();
        cyc(); cyc(); cyc();
        chk("D_step1", {en_w, bus.step_idx}, {3'b010, 3'd1});
        #2;
        aresetn = 1'b0;
        #1;
        chk("D_async_rst", {bus.busy, bus.done, bus.step_idx, en_w, mode_w, hold_w}, 64'd0);
        chk("D_rst_dur", {bus.duration_r, bus.duration_b}, 64'd0);
        #2;
        aresetn = 1'b1;
        cyc();
        wr(3'd0, ent(3'b110, 3'b000, 3'b000, 2));
        wr(3'd1, ent(3'b101, 3'b000, 3'b000, 1));
        bus.seq_last = 3'd1;
        pulse_start();
        chk("D_replay0", {en_w, bus.step_idx, bus.busy}, {3'b110, 3'd0, 1'b1});
        cyc();
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = 3'd1;
        bus.tbl_wdata = ent(3'b111, 3'b000, 3'b000, 1);
        cyc();
        bus.tbl_we    = 1'b0;
        chk("D_prewrite", {en_w, bus.step_idx}, {3'b101, 3'd1});
        cyc();
        chk("D_done", {bus.done, en_w}, {1'b1, 3'b000});
        cyc();
        pulse_start();
        chk("D_restart", en_w, 3'b110);
        cyc(); cyc();
        chk("D_postwrite", en_w, 3'b111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_rgb_pattern_seq.md
# led_rgb_pattern_seq

Pattern sequencer for the RGB LED driver. It steps through a small programmable table of LED states and drives the driver's per-channel mode/enable/holded/duration configuration inputs, one table entry per step, for a programmable dwell time each. It sits between the AXI-Lite register interface and the LED driver, so software can start a multi-step light pattern once and leave the hardware to play it autonomously, optionally looping.

## Interface
- DEPTH, 8: table entries; power of two, 2..64.
- AW, $clog2(DEPTH): table index width (derived).
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  AW  table write index.
- tbl_wdata  in  32  entry: [2:0] enable {b,g,r}, [5:3] mode {b,g,r}, [8:6] holded {b,g,r}, [31:9] dwell (23-bit tick count).
- seq_last  in  AW  index of the last step played (0..DEPTH-1).
- loop_en  in  1  restart at step 0 after seq_last.
- prescale  in  16  tick = prescale+1 clock cycles.
- duration  in  32  blink duration copied to all three duration outputs.
- start  in  1  start pulse, honoured only in IDLE.
- stop  in  1  abort pulse, honoured in any state.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a non-looping sequence completes.
- step_idx  out  AW  current step.
- mode_r/g/b, enable_r/g/b, holded_r/g/b  out  1 each  to the LED driver.
- duration_r/g/b  out  32 each  to the LED driver.

## Operation
- The table is a DEPTH x 32 register array. It is not reset. A write takes effect on the next edge and is allowed in any state.
- States: IDLE, RUN, DONE.
- IDLE: enable_* = 0, busy = 0. If start=1 and stop=0, then at the edge:
  - state becomes RUN, step_idx = 0;
  - mode/enable/holded outputs are loaded from entry 0;
  - the dwell counter is loaded with entry 0's dwell and the prescale counter is cleared.
- RUN: the prescale counter counts 0..prescale and emits a tick on reaching prescale, then wraps to 0. Each tick decrements the dwell counter.
- Step end is a tick with dwell counter = 1. At that edge:
  - if step_idx < seq_last: step_idx+1 and its entry are loaded;
  - if step_idx = seq_last and loop_en=1: step 0 is reloaded;
  - if step_idx = seq_last and loop_en=0: state goes to DONE.
- Dwell = 0 means hold this step indefinitely, until stop. No decrement occurs and the step never ends.
- DONE: lasts one cycle with done=1. enable_* is cleared on entry. Then IDLE.
- stop=1 in any state: next state is IDLE, enable_* = 0, step_idx = 0. stop has priority over start and over a step end in the same cycle.
- start while in RUN or DONE is ignored.
- A table write to the entry being loaded on the same edge: the pre-write contents are loaded.
- seq_last and loop_en are sampled at each step end, not latched at start.
- duration_r/g/b register the duration input every cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, step_idx 0, all mode/enable/holded 0, duration_* 0, counters 0.
- start sampled at edge N: outputs show entry 0 and busy=1 from edge N onward (zero added latency).
- Step k lasts exactly dwell_k x (prescale+1) cycles.
- Step transitions are glitch-free: all nine config bits change on the same edge.
- Last step ends at edge M (loop_en=0): done=1 and enables=0 during cycle M..M+1; IDLE from edge M+1.
- A new start is accepted in the first IDLE cycle.
- Reset asserted mid-sequence: all outputs go to reset values immediately (asynchronous). Table contents are undefined afterwards.

## Configuration
- LED_SEQ_PRESCALE_EN defined: prescaler as described.
- LED_SEQ_PRESCALE_EN undefined: the prescale input is ignored, the prescale counter is not built, every cycle is a tick, and a step lasts dwell cycles.

## Test plan
- Table entries {en=001,dwell=3},{en=010,dwell=2},{en=100,dwell=1}, seq_last=2, loop_en=0, prescale=0, start pulse:
  - enables 001 for 3 cycles, 010 for 2, 100 for 1;
  - then done=1 for one cycle, enables 000, busy back to 0.
- Same table, prescale=4: steps last 15, 10 and 5 cycles.
- loop_en=1, seq_last=1: pattern 001,010,001,010… continues. Clearing loop_en mid-step-1 ends the sequence at the end of step 1 with done.
- Entry 0 with dwell=0: enables stay at entry 0 for 1000 cycles. A stop pulse returns to IDLE next edge with enables=000 and no done pulse.
- start and stop in the same IDLE cycle: stays IDLE. start during RUN: no restart, step_idx unchanged.
- aresetn dropped during step 1: all outputs reset asynchronously. After release, a start replays from step 0 using freshly written entries.
